// File: rtl/phase_sequencer.sv
// Phase sequencer / run controller: issues phases 1..NUM_PHASES per instruction, 0 when idle.
// Optional stall watchdog enabled by defining PHASE_SEQ_STALL_TIMEOUT_EN.
module phase_sequencer #(
  parameter int unsigned SIZE_CNT   = 3,
  parameter int unsigned NUM_PHASES = 6,
  parameter int unsigned ICNT_W     = 16,
  parameter int unsigned STALL_MAX  = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic                step_req,
  input  logic                halt_req,
  input  logic                stall,
  output logic [SIZE_CNT-1:0] cnt,
  output logic                instr_done,
  output logic                halted,
  output logic [ICNT_W-1:0]   instr_count,
  output logic                stall_timeout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2
  } state_e;

  localparam logic [SIZE_CNT-1:0] LAST_PHASE  = SIZE_CNT'(NUM_PHASES);
  localparam logic [SIZE_CNT-1:0] FIRST_PHASE = SIZE_CNT'(1);

  // Reject parameter sets the phase counter cannot represent.
  if ((NUM_PHASES < 2) || (NUM_PHASES >= (1 << SIZE_CNT)) || (STALL_MAX < 1)) begin : g_cfg_check
    $error("phase_sequencer: illegal parameterisation");
  end

  state_e                state_q, state_d;
  logic [SIZE_CNT-1:0]   cnt_q, cnt_d;
  logic                  done_q, done_d;
  logic                  halted_q, halted_d;
  logic [ICNT_W-1:0]     icnt_q, icnt_d;
  logic                  halt_pend_q, halt_pend_d;
  logic                  force_adv_c;
  logic                  adv_c;

`ifdef PHASE_SEQ_STALL_TIMEOUT_EN
  localparam int unsigned STALL_W = $clog2(STALL_MAX + 1);

  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
  logic               timeout_q;

  // Consecutive stalled active cycles; the STALL_MAX-th one is forced through.
  always_comb begin
    stall_cnt_d = '0;
    force_adv_c = 1'b0;
    if ((state_q != S_IDLE) && stall) begin
      if (stall_cnt_q == STALL_W'(STALL_MAX - 1)) begin
        force_adv_c = 1'b1;
      end else begin
        stall_cnt_d = stall_cnt_q + STALL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      timeout_q   <= force_adv_c;
    end
  end

  assign stall_timeout = timeout_q;
`else
  assign force_adv_c   = 1'b0;
  assign stall_timeout = 1'b0;
`endif

  assign adv_c = !stall || force_adv_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      halted_q    <= 1'b1;
      icnt_q      <= '0;
      halt_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      halted_q    <= halted_d;
      icnt_q      <= icnt_d;
      halt_pend_q <= halt_pend_d;
    end
  end

  // Next-state: start from IDLE, advance phases, decide continue/stop at the boundary.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    halted_d    = halted_q;
    icnt_d      = icnt_q;
    halt_pend_d = halt_pend_q;

    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d  = S_RUN;
          cnt_d    = FIRST_PHASE;
          halted_d = 1'b0;
        end else if (step_req) begin
          state_d  = S_STEP;
          cnt_d    = FIRST_PHASE;
          halted_d = 1'b0;
        end
      end
      default: begin
        if (halt_req) begin
          halt_pend_d = 1'b1;
        end
        if (adv_c) begin
          if (cnt_q != LAST_PHASE) begin
            cnt_d = cnt_q + SIZE_CNT'(1);
          end else begin
            done_d = 1'b1;
            icnt_d = icnt_q + ICNT_W'(1);
            if ((state_q == S_RUN) && run && !halt_pend_q && !halt_req) begin
              cnt_d = FIRST_PHASE;
            end else begin
              cnt_d       = '0;
              state_d     = S_IDLE;
              halted_d    = 1'b1;
              halt_pend_d = 1'b0;
            end
          end
        end
      end
    endcase
  end

  assign cnt         = cnt_q;
  assign instr_done  = done_q;
  assign halted      = halted_q;
  assign instr_count = icnt_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: directed scenarios plus randomized run against a transaction-level model.
module tb_phase_sequencer;

  localparam int unsigned SIZE_CNT   = 3;
  localparam int unsigned NUM_PHASES = 6;
  localparam int unsigned ICNT_W     = 16;
  localparam int unsigned STALL_MAX  = 15;
  localparam int unsigned VW         = SIZE_CNT + ICNT_W + 3;

  logic                clk = 1'b0;
  logic                reset, run, step_req, halt_req, stall;
  logic [SIZE_CNT-1:0] cnt;
  logic                instr_done, halted, stall_timeout;
  logic [ICNT_W-1:0]   instr_count;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state: phase 0 means idle, otherwise the phase of the running instruction.
  int m_cnt, m_icnt;
  bit m_done, m_halted, m_to, m_runmode, m_pend;
`ifdef PHASE_SEQ_STALL_TIMEOUT_EN
  int m_sc;
`endif

  phase_sequencer #(
    .SIZE_CNT(SIZE_CNT), .NUM_PHASES(NUM_PHASES), .ICNT_W(ICNT_W), .STALL_MAX(STALL_MAX)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .step_req(step_req), .halt_req(halt_req),
    .stall(stall), .cnt(cnt), .instr_done(instr_done), .halted(halted),
    .instr_count(instr_count), .stall_timeout(stall_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (time %0t, required < 1000000)", $time);
    $fatal(1);
  end

  task automatic model_step(input bit rst, input bit r, input bit s, input bit h, input bit st);
    bit adv, keep;
    if (rst) begin
      m_cnt = 0; m_icnt = 0; m_done = 0; m_halted = 1; m_to = 0; m_pend = 0; m_runmode = 0;
`ifdef PHASE_SEQ_STALL_TIMEOUT_EN
      m_sc = 0;
`endif
      return;
    end
    m_done = 0;
    m_to   = 0;
    if (m_cnt == 0) begin
`ifdef PHASE_SEQ_STALL_TIMEOUT_EN
      m_sc = 0;
`endif
      if (r || s) begin
        m_cnt = 1; m_runmode = r; m_halted = 0;
      end
      return;
    end
    adv = !st;
`ifdef PHASE_SEQ_STALL_TIMEOUT_EN
    if (st) begin
      m_sc++;
      if (m_sc == STALL_MAX) begin
        adv = 1; m_to = 1;
      end
    end
    if (adv) m_sc = 0;
`endif
    keep = m_runmode && r && !m_pend && !h;
    if (h) m_pend = 1;
    if (!adv) return;
    if (m_cnt < NUM_PHASES) begin
      m_cnt++;
    end else begin
      m_done = 1;
      m_icnt = (m_icnt + 1) % (1 << ICNT_W);
      if (keep) m_cnt = 1;
      else begin
        m_cnt = 0; m_halted = 1; m_pend = 0;
      end
    end
  endtask

  task automatic cyc();
    bit rs, r, s, h, st;
    rs = reset; r = run; s = step_req; h = halt_req; st = stall;
    @(posedge clk);
    #1;
    model_step(rs, r, s, h, st);
  endtask

  task automatic do_reset();
    reset = 1; run = 0; step_req = 0; halt_req = 0; stall = 0;
    cyc();
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1; run = 1; step_req = 1; halt_req = 1; stall = 1;
    cyc(); cyc();
    n_cmp++;
    if ({cnt, instr_done, halted, stall_timeout} !== {SIZE_CNT'(0), 1'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_outputs: cnt=%0d done=%b halted=%b to=%b, required 0 0 1 0",
               cnt, instr_done, halted, stall_timeout);
    end
    n_cmp++;
    if (instr_count !== ICNT_W'(0)) begin
      n_fail++;
      $display("FAIL reset_icount: got %0d, required 0", instr_count);
    end
    reset = 0; run = 0; step_req = 0; halt_req = 0; stall = 0;
  endtask

  task automatic test_free_run();
    do_reset();
    run = 1;
    for (int k = 0; k < 19; k++) begin
      cyc();
      n_cmp++;
      if ({cnt, instr_done, halted} !==
          {SIZE_CNT'(k % NUM_PHASES + 1), (k > 0) && (k % NUM_PHASES == 0), 1'b0}) begin
        n_fail++;
        $display("FAIL free_run[%0d]: cnt=%0d done=%b halted=%b, required cnt=%0d done=%b halted=0",
                 k, cnt, instr_done, halted, k % NUM_PHASES + 1, (k > 0) && (k % NUM_PHASES == 0));
      end
    end
    n_cmp++;
    if (instr_count !== ICNT_W'(3)) begin
      n_fail++;
      $display("FAIL free_run_icount: got %0d, required 3", instr_count);
    end
    run = 0;
  endtask

  task automatic test_step();
    do_reset();
    for (int n = 1; n <= 2; n++) begin
      step_req = 1;
      cyc();
      step_req = 0;
      n_cmp++;
      if ({cnt, halted} !== {SIZE_CNT'(1), 1'b0}) begin
        n_fail++;
        $display("FAIL step_start[%0d]: cnt=%0d halted=%b, required 1 0", n, cnt, halted);
      end
      for (int p = 2; p <= NUM_PHASES; p++) begin
        cyc();
        n_cmp++;
        if ({cnt, instr_done} !== {SIZE_CNT'(p), 1'b0}) begin
          n_fail++;
          $display("FAIL step_phase[%0d]: cnt=%0d done=%b, required %0d 0", p, cnt, instr_done, p);
        end
      end
      cyc();
      n_cmp++;
      if ({cnt, instr_done, halted, instr_count} !== {SIZE_CNT'(0), 1'b1, 1'b1, ICNT_W'(n)}) begin
        n_fail++;
        $display("FAIL step_end[%0d]: cnt=%0d done=%b halted=%b icnt=%0d, required 0 1 1 %0d",
                 n, cnt, instr_done, halted, instr_count, n);
      end
      cyc();
      n_cmp++;
      if ({cnt, instr_done, halted} !== {SIZE_CNT'(0), 1'b0, 1'b1}) begin
        n_fail++;
        $display("FAIL step_idle[%0d]: cnt=%0d done=%b halted=%b, required 0 0 1",
                 n, cnt, instr_done, halted);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    run = 1;
    repeat (4) cyc();
    stall = 1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      n_cmp++;
      if ({cnt, instr_done} !== {SIZE_CNT'(4), 1'b0}) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: cnt=%0d done=%b, required 4 0", k, cnt, instr_done);
      end
    end
    stall = 0;
    for (int p = 5; p <= NUM_PHASES + 1; p++) begin
      cyc();
      n_cmp++;
      if ({cnt, instr_done} !== {SIZE_CNT'((p > NUM_PHASES) ? 1 : p), p > NUM_PHASES}) begin
        n_fail++;
        $display("FAIL stall_after[%0d]: cnt=%0d done=%b", p, cnt, instr_done);
      end
    end
    n_cmp++;
    if (instr_count !== ICNT_W'(1)) begin
      n_fail++;
      $display("FAIL stall_icount: got %0d, required 1", instr_count);
    end
    run = 0;
  endtask

  task automatic test_halt();
    do_reset();
    run = 1;
    cyc(); cyc();
    halt_req = 1;
    cyc();
    halt_req = 0;
    for (int p = 4; p <= NUM_PHASES; p++) begin
      cyc();
      n_cmp++;
      if ({cnt, instr_done} !== {SIZE_CNT'(p), 1'b0}) begin
        n_fail++;
        $display("FAIL halt_phase[%0d]: cnt=%0d done=%b, required %0d 0", p, cnt, instr_done, p);
      end
    end
    cyc();
    n_cmp++;
    if ({cnt, instr_done, halted, instr_count} !== {SIZE_CNT'(0), 1'b1, 1'b1, ICNT_W'(1)}) begin
      n_fail++;
      $display("FAIL halt_stop: cnt=%0d done=%b halted=%b icnt=%0d, required 0 1 1 1",
               cnt, instr_done, halted, instr_count);
    end
    cyc();
    n_cmp++;
    if ({cnt, instr_done, halted} !== {SIZE_CNT'(1), 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL halt_restart: cnt=%0d done=%b halted=%b, required 1 0 0", cnt, instr_done, halted);
    end
    run = 0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    run = 1;
    repeat (5) cyc();
    reset = 1;
    cyc();
    reset = 0; run = 0;
    n_cmp++;
    if ({cnt, instr_done, halted, instr_count} !== {SIZE_CNT'(0), 1'b0, 1'b1, ICNT_W'(0)}) begin
      n_fail++;
      $display("FAIL reset_mid: cnt=%0d done=%b halted=%b icnt=%0d, required 0 0 1 0",
               cnt, instr_done, halted, instr_count);
    end
    cyc();
    n_cmp++;
    if ({cnt, instr_done} !== {SIZE_CNT'(0), 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid_after: cnt=%0d done=%b, required 0 0", cnt, instr_done);
    end
  endtask

  task automatic test_priority();
    do_reset();
    halt_req = 1;
    cyc();
    halt_req = 0;
    run = 1; step_req = 1;
    cyc();
    step_req = 0;
    repeat (2) cyc();
    step_req = 1;
    cyc();
    step_req = 0;
    repeat (NUM_PHASES - 4) cyc();
    cyc();
    n_cmp++;
    if ({cnt, instr_done, halted, instr_count} !== {SIZE_CNT'(1), 1'b1, 1'b0, ICNT_W'(1)}) begin
      n_fail++;
      $display("FAIL run_over_step: cnt=%0d done=%b halted=%b icnt=%0d, required 1 1 0 1",
               cnt, instr_done, halted, instr_count);
    end
    run = 0;
  endtask

  task automatic test_stall_timeout();
    bit [SIZE_CNT-1:0] exp_cnt;
    bit                exp_to;
    do_reset();
    run = 1;
    repeat (3) cyc();
    stall = 1;
    for (int k = 1; k <= 20; k++) begin
      cyc();
`ifdef PHASE_SEQ_STALL_TIMEOUT_EN
      exp_cnt = SIZE_CNT'((k < 15) ? 3 : 4);
      exp_to  = (k == 15);
`else
      exp_cnt = SIZE_CNT'(3);
      exp_to  = 1'b0;
`endif
      n_cmp++;
      if ({cnt, stall_timeout} !== {exp_cnt, exp_to}) begin
        n_fail++;
        $display("FAIL stall_timeout[%0d]: cnt=%0d to=%b, required %0d %b",
                 k, cnt, stall_timeout, exp_cnt, exp_to);
      end
    end
    stall = 0; run = 0;
  endtask

  task automatic test_random();
    logic [VW-1:0] got, exp;
    int stall_left = 0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) run = ~run;
      step_req = ($urandom_range(0, 5) == 0);
      halt_req = ($urandom_range(0, 11) == 0);
      reset    = ($urandom_range(0, 299) == 0);
      if (stall_left > 0) stall_left--;
      else if ($urandom_range(0, 9) == 0) stall_left = $urandom_range(1, 20);
      stall = (stall_left > 0);
      cyc();
      got = {cnt, instr_done, halted, instr_count, stall_timeout};
      exp = {SIZE_CNT'(m_cnt), m_done, m_halted, ICNT_W'(m_icnt), m_to};
      n_cmp++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL random[%0d]: cnt/done/halted/icnt/to got %0d/%b/%b/%0d/%b, required %0d/%b/%b/%0d/%b",
                 i, cnt, instr_done, halted, instr_count, stall_timeout,
                 m_cnt, m_done, m_halted, m_icnt, m_to);
      end
    end
    reset = 0; run = 0; step_req = 0; halt_req = 0; stall = 0;
  endtask

  initial begin
    reset = 1; run = 0; step_req = 0; halt_req = 0; stall = 0;
    test_reset();
    test_free_run();
    test_step();
    test_stall();
    test_halt();
    test_reset_mid();
    test_priority();
    test_stall_timeout();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
